// File: rtl/ncl_adder_pipe_stage.sv
// Dual-rail (NCL-style) adder/subtractor stage with a registered four-phase DATA/NULL handshake,
// a sticky invalid-encoding flag and a counter of accepted DATA wavefronts.
module ncl_adder_pipe_stage #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [1:0]         cin,
  input  logic [1:0]         sub,
  input  logic               ki,
  output logic               ko,
  output logic [2*WIDTH-1:0] s,
  output logic [1:0]         cout,
  output logic [1:0]         overflow,
  output logic               err,
  output logic [CNT_W-1:0]   wave_cnt
);

  localparam int unsigned NDIG  = 2 * WIDTH + 2;
  localparam int unsigned NRAIL = 2 * NDIG;
  localparam int unsigned RW    = WIDTH + 1;

  typedef enum logic {WAIT_DATA, DATA_OUT} state_t;

  state_t             state, state_nxt;
  logic               ko_nxt, err_nxt;
  logic [2*WIDTH-1:0] s_nxt;
  logic [1:0]         cout_nxt, ovf_nxt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [NRAIL-1:0]   rails;
  logic [NDIG-1:0]    dig_valid, dig_inv;
  logic               complete, all_null, any_inv;

  logic [WIDTH-1:0]   a_val, b_val, b_eff;
  logic               c_eff;
  logic [RW-1:0]      sum;
  logic               ovf_bit;
  logic [2*WIDTH-1:0] s_enc;

  assign rails = {sub, cin, b, a};

  // Per-digit classification of the whole input set
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign dig_valid[g] = rails[2*g+1] ^ rails[2*g];
    assign dig_inv[g]   = rails[2*g+1] & rails[2*g];
  end

  assign complete = &dig_valid;
  assign all_null = ~|rails;
  assign any_inv  = |dig_inv;

  for (genvar g = 0; g < WIDTH; g++) begin : g_val
    assign a_val[g]     = a[2*g+1];
    assign b_val[g]     = b[2*g+1];
    assign s_enc[2*g+1] = sum[g];
    assign s_enc[2*g]   = ~sum[g];
  end

  // Subtract as A + ~B + (1 - c): cin becomes borrow-in
  assign b_eff   = sub[1] ? ~b_val : b_val;
  assign c_eff   = cin[1] ^ sub[1];
  assign sum     = {1'b0, a_val} + {1'b0, b_eff} + RW'(c_eff);
  assign ovf_bit = (a_val[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_val[WIDTH-1]);

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    ko_nxt    = ko;
    s_nxt     = s;
    cout_nxt  = cout;
    ovf_nxt   = overflow;
    cnt_nxt   = wave_cnt;
    err_nxt   = err | any_inv;
    case (state)
      WAIT_DATA: begin
        if (complete && ki && !any_inv) begin
          state_nxt = DATA_OUT;
          ko_nxt    = 1'b0;
          s_nxt     = s_enc;
          cout_nxt  = {sum[WIDTH], ~sum[WIDTH]};
          ovf_nxt   = {ovf_bit, ~ovf_bit};
          cnt_nxt   = wave_cnt + CNT_W'(1);
        end
      end
      DATA_OUT: begin
        if (all_null && !ki) begin
          state_nxt = WAIT_DATA;
          ko_nxt    = 1'b1;
          s_nxt     = '0;
          cout_nxt  = 2'b00;
          ovf_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = WAIT_DATA;
        ko_nxt    = 1'b1;
        s_nxt     = '0;
        cout_nxt  = 2'b00;
        ovf_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT_DATA;
      ko       <= 1'b1;
      s        <= '0;
      cout     <= 2'b00;
      overflow <= 2'b00;
      err      <= 1'b0;
      wave_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ko       <= ko_nxt;
      s        <= s_nxt;
      cout     <= cout_nxt;
      overflow <= ovf_nxt;
      err      <= err_nxt;
      wave_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ncl_adder_pipe_stage.sv
// Directed, table-driven bench for ncl_adder_pipe_stage (WIDTH=4), with a CNT_W=2 twin
// instance sharing the same inputs to exercise counter wrap.
module tb_ncl_adder_pipe_stage;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [1:0] cin, sub;
  logic       ki;

  logic       ko, err, ko2, err2;
  logic [7:0] s, s2;
  logic [1:0] cout, overflow, cout2, ovf2;
  logic [7:0] wave_cnt;
  logic [1:0] wave_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  ncl_adder_pipe_stage #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .ki(ki),
    .ko(ko), .s(s), .cout(cout), .overflow(overflow), .err(err), .wave_cnt(wave_cnt)
  );

  ncl_adder_pipe_stage #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub), .ki(ki),
    .ko(ko2), .s(s2), .cout(cout2), .overflow(ovf2), .err(err2), .wave_cnt(wave_cnt2)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] av, bv;
    logic       cv, mv;
    logic [3:0] sv;
    logic       co, ov;
  } vec_t;

  function automatic logic [7:0] enc4(input logic [3:0] v);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic [1:0] enc1(input logic v);
    return {v, ~v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                       input logic mv, input logic k);
    a = enc4(av); b = enc4(bv); cin = enc1(cv); sub = enc1(mv); ki = k;
  endtask

  task automatic drive_null(input logic k);
    a = '0; b = '0; cin = '0; sub = '0; ki = k;
  endtask

  vec_t vecs [11];

  initial begin
    // {A, B, cin, sub(1=sub), expected S, cout, overflow}
    vecs[0]  = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[1]  = '{4'h3, 4'h5, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0};
    vecs[2]  = '{4'h5, 4'h3, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1};
    vecs[3]  = '{4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[4]  = '{4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1};
    vecs[5]  = '{4'h5, 4'h3, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0};
    vecs[6]  = '{4'h8, 4'h1, 1'b0, 1'b1, 4'h7, 1'b1, 1'b1};
    vecs[7]  = '{4'h4, 4'h4, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0};
    vecs[8]  = '{4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 1'b0};
    vecs[10] = '{4'h7, 4'h8, 1'b0, 1'b1, 4'hF, 1'b0, 1'b1};

    // Asynchronous reset with no clock running
    drive_null(1'b1);
    rst = 1'b1;
    #1;
    chk("reset_s", 32'(s), 32'h00);
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    chk("reset_ko", 32'(ko), 32'h1);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_cnt", 32'(wave_cnt), 32'h0);
    #3;
    rst = 1'b0;
    clk_en = 1'b1;
    tick();

    // Spot checks of the literal encodings
    drive(4'h7, 4'h1, 1'b0, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    chk("add_ovf_s_raw", 32'(s), 32'h95);
    chk("add_ovf_cout_raw", 32'(cout), 32'h1);
    chk("add_ovf_ovf_raw", 32'(overflow), 32'h2);
    chk("add_ovf_cnt", 32'(wave_cnt), 32'h1);
    drive_null(1'b0);
    tick();
    drive(4'h3, 4'h5, 1'b0, 1'b1, 1'b1);
    tick();
    exp_cnt++;
    chk("sub_s_raw", 32'(s), 32'hA9);
    chk("sub_cout_raw", 32'(cout), 32'h1);
    chk("sub_ovf_raw", 32'(overflow), 32'h1);
    drive_null(1'b0);
    tick();

    // Table: accept, hold with ki=0, return to NULL
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].av, vecs[i].bv, vecs[i].cv, vecs[i].mv, 1'b1);
      tick();
      exp_cnt++;
      chk($sformatf("v%0d_s", i), 32'(s), 32'(enc4(vecs[i].sv)));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(enc1(vecs[i].co)));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(enc1(vecs[i].ov)));
      chk($sformatf("v%0d_ko", i), 32'(ko), 32'h0);
      chk($sformatf("v%0d_cnt", i), 32'(wave_cnt), 32'(exp_cnt));
      ki = 1'b0;
      tick();
      chk($sformatf("v%0d_hold_s", i), 32'(s), 32'(enc4(vecs[i].sv)));
      drive_null(1'b0);
      tick();
      chk($sformatf("v%0d_null_s", i), 32'(s), 32'h00);
      chk($sformatf("v%0d_null_cout", i), 32'(cout), 32'h0);
      chk($sformatf("v%0d_null_ko", i), 32'(ko), 32'h1);
    end

    // DATA with ki=0 in WAIT_DATA is not accepted until ki=1
    drive(4'h2, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("ki0_noacc_ko", 32'(ko), 32'h1);
    chk("ki0_noacc_s", 32'(s), 32'h00);
    ki = 1'b1;
    tick();
    exp_cnt++;
    chk("ki1_acc_s", 32'(s), 32'(enc4(4'h5)));
    chk("ki1_acc_cnt", 32'(wave_cnt), 32'(exp_cnt));

    // In DATA_OUT: new DATA, ki=1 + ALLNULL, partial NULL all hold
    drive(4'h9, 4'h9, 1'b1, 1'b0, 1'b1);
    tick();
    chk("dout_newdata_s", 32'(s), 32'(enc4(4'h5)));
    chk("dout_newdata_cnt", 32'(wave_cnt), 32'(exp_cnt));
    drive_null(1'b1);
    tick();
    chk("dout_ki1null_ko", 32'(ko), 32'h0);
    drive(4'h9, 4'h9, 1'b1, 1'b0, 1'b0);
    a = '0;
    tick();
    chk("dout_partial_ko", 32'(ko), 32'h0);
    chk("dout_partial_s", 32'(s), 32'(enc4(4'h5)));
    drive_null(1'b0);
    tick();
    chk("dout_release_ko", 32'(ko), 32'h1);

    // Partial set in WAIT_DATA is not accepted
    drive(4'h1, 4'h1, 1'b0, 1'b0, 1'b1);
    b[3:2] = 2'b00;
    tick();
    chk("wait_partial_ko", 32'(ko), 32'h1);
    chk("wait_partial_cnt", 32'(wave_cnt), 32'(exp_cnt));

    // Invalid digit: flagged, not accepted, later clean set accepted, err sticky
    drive(4'h1, 4'h2, 1'b0, 1'b0, 1'b1);
    a[1:0] = 2'b11;
    tick();
    chk("inv_err", 32'(err), 32'h1);
    chk("inv_ko", 32'(ko), 32'h1);
    chk("inv_s", 32'(s), 32'h00);
    chk("inv_cnt", 32'(wave_cnt), 32'(exp_cnt));
    a[1:0] = 2'b01;
    tick();
    exp_cnt++;
    chk("inv_clean_s", 32'(s), 32'(enc4(4'h2)));
    chk("inv_clean_err", 32'(err), 32'h1);
    drive_null(1'b0);
    tick();
    chk("inv_null_err", 32'(err), 32'h1);

    // Reset mid-DATA_OUT acts without a clock edge
    drive(4'h6, 4'h1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pre_rst_ko", 32'(ko), 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_rst_s", 32'(s), 32'h00);
    chk("mid_rst_ovf", 32'(overflow), 32'h0);
    chk("mid_rst_ko", 32'(ko), 32'h1);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_cnt", 32'(wave_cnt), 32'h0);
    drive_null(1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Five wavefronts: CNT_W=2 instance wraps to 1
    for (int i = 0; i < 5; i++) begin
      drive(4'(i), 4'h1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_null(1'b0);
      tick();
    end
    chk("wrap_cnt2", 32'(wave_cnt2), 32'h1);
    chk("wrap_cnt8", 32'(wave_cnt), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
